// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int DATA_W    = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic              cpu_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [5:0]        func,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int                CNT_W    = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_ITERS - 1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);
    localparam logic [5:0]        FN_MULT  = 6'b011000;
    localparam logic [5:0]        FN_MULTU = 6'b011001;
    localparam logic [5:0]        FN_DIV   = 6'b011010;
    localparam logic [5:0]        FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dbz_out_q, dbz_out_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sgn_q, sgn_d;
    logic                is_div_q, is_div_d;
    logic                dbz_q, dbz_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;

    logic                w_is_mul;
    logic                w_is_div;
    logic                w_signed_div;
    logic                w_accept;
    logic [DATA_W-1:0]   w_a_abs;
    logic [DATA_W-1:0]   w_b_abs;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_sub;
    logic                w_ge;

    assign w_is_mul     = (func == FN_MULT) || (func == FN_MULTU);
    assign w_is_div     = (func == FN_DIV)  || (func == FN_DIVU);
    assign w_signed_div = (func == FN_DIV);
    assign w_accept     = (state_q == ST_IDLE) && start && !flush && (w_is_mul || w_is_div);
    assign w_a_abs      = (w_signed_div && dataA[DATA_W-1]) ? (~dataA + ONE) : dataA;
    assign w_b_abs      = (w_signed_div && dataB[DATA_W-1]) ? (~dataB + ONE) : dataB;

    // Sign/zero-extend to full product width; the low 2*DATA_W bits are exact either way.
    assign w_a_ext = {{DATA_W{sgn_q & op_a_q[DATA_W-1]}}, op_a_q};
    assign w_b_ext = {{DATA_W{sgn_q & op_b_q[DATA_W-1]}}, op_b_q};
    assign w_prod  = w_a_ext * w_b_ext;

    // op_a_q doubles as the dividend shifter and the quotient accumulator.
    assign w_rem_sh = {rem_q, op_a_q[DATA_W-1]};
    assign w_sub    = w_rem_sh - {1'b0, op_b_q};
    assign w_ge     = (w_rem_sh >= {1'b0, op_b_q});

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        dbz_out_d = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rem_d     = rem_q;
        prod_d    = prod_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        is_div_d  = is_div_q;
        dbz_d     = dbz_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;

        case (state_q)
            ST_IDLE: begin
                if (mthi) hi_d = dataA;
                if (mtlo) lo_d = dataA;
                if (w_accept && w_is_mul) begin
                    op_a_d   = dataA;
                    op_b_d   = dataB;
                    sgn_d    = (func == FN_MULT);
                    is_div_d = 1'b0;
                    dbz_d    = 1'b0;
                    state_d  = ST_MUL;
                end else if (w_accept) begin
                    is_div_d = 1'b1;
                    cnt_d    = '0;
                    rem_d    = '0;
                    q_neg_d  = w_signed_div & (dataA[DATA_W-1] ^ dataB[DATA_W-1]);
                    r_neg_d  = w_signed_div & dataA[DATA_W-1];
                    op_b_d   = w_b_abs;
                    if (dataB == '0) begin
                        // Raw dividend is kept so HI receives dataA unmodified.
                        op_a_d  = dataA;
                        dbz_d   = 1'b1;
                        state_d = ST_FIX;
                    end else begin
                        op_a_d  = w_a_abs;
                        dbz_d   = 1'b0;
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                prod_d  = w_prod;
                state_d = ST_FIX;
            end
            ST_DIV: begin
                rem_d  = w_ge ? w_sub[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
                op_a_d = {op_a_q[DATA_W-2:0], w_ge};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_q;
                end else if (dbz_q) begin
                    lo_d = '1;
                    hi_d = op_a_q;
                end else begin
                    lo_d = q_neg_q ? (~op_a_q + ONE) : op_a_q;
                    hi_d = r_neg_q ? (~rem_q + ONE) : rem_q;
                end
                done_d    = 1'b1;
                dbz_out_d = dbz_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            hi_d      = hi_q;
            lo_d      = lo_q;
            done_d    = 1'b0;
            dbz_out_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge cpu_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rem_q     <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            is_div_q  <= 1'b0;
            dbz_q     <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_out_q <= dbz_out_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rem_q     <= rem_d;
            prod_q    <= prod_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            is_div_q  <= is_div_d;
            dbz_q     <= dbz_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Directed and random checks of ex_muldiv_unit against an
//            arithmetic reference model of MULT/MULTU/DIV/DIVU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        cpu_clk;
    logic        reset;
    logic        start;
    logic [5:0]  func;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        mthi;
    logic        mtlo;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    ex_muldiv_unit #(.DATA_W(32), .DIV_ITERS(32)) dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .start      (start),
        .func       (func),
        .dataA      (dataA),
        .dataB      (dataB),
        .mthi       (mthi),
        .mtlo       (mtlo),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi         (hi),
        .lo         (lo)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} as the architecture defines them.
    function automatic logic [63:0] ref_op(input logic [5:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
        int              ia, ib;
        longint          sa, sb, q, rm;
        longint unsigned ua, ub, uq, urm;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'd0, a};
        ub = {32'd0, b};
        ref_op = '0;
        case (f)
            F_MULT: begin
                q = sa * sb;
                ref_op = q;
            end
            F_MULTU: ref_op = ua * ub;
            F_DIV: begin
                if (b == 32'd0) ref_op = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    ref_op = {rm[31:0], q[31:0]};
                end
            end
            F_DIVU: begin
                if (b == 32'd0) ref_op = {a, 32'hFFFF_FFFF};
                else begin
                    uq  = ua / ub;
                    urm = ua % ub;
                    ref_op = {urm[31:0], uq[31:0]};
                end
            end
            default: ref_op = '0;
        endcase
    endfunction

    // Edges after the accepting edge until done is visible.
    function automatic int ref_lat(input logic [5:0] f, input logic [31:0] b);
        if (f == F_MULT || f == F_MULTU) return 2;
        if (b == 32'd0) return 1;
        return 33;
    endfunction

    task automatic wait_done(output int n, output int bcnt);
        n    = 0;
        bcnt = 0;
        while (done !== 1'b1 && n < 60) begin
            if (busy === 1'b1) bcnt++;
            step();
            n++;
        end
    endtask

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] exp;
        int          n;
        int          bcnt;
        exp   = ref_op(f, a, b);
        func  = f;
        dataA = a;
        dataB = b;
        start = 1'b1;
        step();
        start = 1'b0;
        dataA = $urandom;
        dataB = $urandom;
        wait_done(n, bcnt);
        chk({tag, ".done"}, done, 1);
        chk({tag, ".latency"}, n, ref_lat(f, b));
        chk({tag, ".busy_cycles"}, bcnt, ref_lat(f, b));
        chk({tag, ".busy_at_done"}, busy, 0);
        chk({tag, ".hilo"}, {hi, lo}, exp);
        chk({tag, ".dbz"}, div_by_zero, ((f == F_DIV || f == F_DIVU) && b == 32'd0) ? 1 : 0);
        step();
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".dbz_pulse"}, div_by_zero, 0);
    endtask

    initial begin
        logic [5:0]  codes [4];
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          n;
        int          bcnt;
        bit          seen;

        codes[0] = F_MULT;
        codes[1] = F_MULTU;
        codes[2] = F_DIV;
        codes[3] = F_DIVU;

        reset = 1'b1;
        start = 1'b0;
        func  = 6'd0;
        dataA = 32'd0;
        dataB = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        flush = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.dbz", div_by_zero, 0);
        chk("rst.hilo", {hi, lo}, 64'd0);
        step();
        step();
        reset = 1'b1;
        step();

        run_op(F_MULT,  32'hFFFF_FFFE, 32'd3,         "mult_neg");
        chk("mult_neg.value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("multu_max.value", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg7_2");
        chk("div_neg7_2.value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(F_DIVU,  32'd7,         32'd2,         "divu_7_2");
        chk("divu_7_2.value", {hi, lo}, {32'd1, 32'd3});
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf.value", {hi, lo}, {32'd0, 32'h8000_0000});
        run_op(F_DIV,   32'd5,         32'd0,         "div_by0");
        chk("div_by0.value", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op(F_DIV,   32'hFFFF_FFF0, 32'd0,         "div_by0_neg");

        // Unknown function code is ignored.
        func  = 6'b100000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("badfunc.busy", busy, 0);
        step();
        chk("badfunc.done", done, 0);

        // Flush alongside start in IDLE blocks acceptance.
        func  = F_MULT;
        dataA = 32'd9;
        dataB = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        step();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start.busy", busy, 0);

        // mthi/mtlo with an accepted start: written at once, then overwritten.
        func  = F_MULT;
        dataA = 32'd7;
        dataB = 32'd6;
        start = 1'b1;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        step();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        chk("mt_start.hi", hi, 7);
        chk("mt_start.lo", lo, 7);
        wait_done(n, bcnt);
        chk("mt_start.done", done, 1);
        chk("mt_start.hilo", {hi, lo}, 64'd42);
        step();

        // Start and mthi during a busy DIVU are both ignored.
        exp   = ref_op(F_DIVU, 32'd1000, 32'd7);
        func  = F_DIVU;
        dataA = 32'd1000;
        dataB = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        func  = F_MULT;
        dataA = 32'h0000_DEAD;
        dataB = 32'd3;
        start = 1'b1;
        mthi  = 1'b1;
        step();
        start = 1'b0;
        mthi  = 1'b0;
        chk("busy_ignore.hi", hi, 42'd0);
        wait_done(n, bcnt);
        chk("busy_ignore.done", done, 1);
        chk("busy_ignore.hilo", {hi, lo}, exp);
        step();
        chk("busy_ignore.idle", busy, 0);

        // Flush mid-division leaves HI/LO untouched and never raises done.
        dataA = 32'h0000_AAAA;
        mthi  = 1'b1;
        step();
        mthi  = 1'b0;
        dataA = 32'h0000_5555;
        mtlo  = 1'b1;
        step();
        mtlo  = 1'b0;
        chk("preload.hi", hi, 32'h0000_AAAA);
        chk("preload.lo", lo, 32'h0000_5555);
        func  = F_DIVU;
        dataA = 32'd100;
        dataB = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush.busy", busy, 0);
        chk("flush.done", done, 0);
        chk("flush.hilo", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        chk("flush.no_done", seen, 0);
        chk("flush.hilo_late", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
        run_op(F_MULTU, 32'd4, 32'd5, "after_flush");
        chk("after_flush.value", {hi, lo}, 64'd20);

        // Asynchronous reset mid-division.
        func  = F_DIV;
        dataA = 32'h0000_1000;
        dataB = 32'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        #2 reset = 1'b0;
        #1;
        chk("async_rst.busy", busy, 0);
        chk("async_rst.done", done, 0);
        chk("async_rst.hilo", {hi, lo}, 64'd0);
        #2 reset = 1'b1;
        step();
        dataA = 32'h0000_1234;
        mtlo  = 1'b1;
        step();
        mtlo  = 1'b0;
        chk("mtlo_idle.lo", lo, 32'h0000_1234);
        chk("mtlo_idle.hi", hi, 32'd0);

        // mthi while a signed divide is in flight.
        exp   = ref_op(F_DIV, 32'd50, 32'd7);
        func  = F_DIV;
        dataA = 32'd50;
        dataB = 32'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        dataA = 32'h0000_DEAD;
        mthi  = 1'b1;
        step();
        mthi  = 1'b0;
        chk("mthi_busy.hi", hi, 32'd0);
        wait_done(n, bcnt);
        chk("mthi_busy.done", done, 1);
        chk("mthi_busy.hilo", {hi, lo}, exp);
        step();

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            f = codes[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            run_op(f, a, b, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
